// File: rtl/tl_ul_buffer.sv
// tl_ul_buffer: registered TL-UL buffer stage for the 32-bit peripheral bus.
//
// It sits between the crossbar (in side) and the peripheral fabric (out side).
// There is one independent circular FIFO per direction:
//   A channel (requests):  auto_in_a_*  -> FIFO -> auto_out_a_*
//   D channel (responses): auto_out_d_* -> FIFO -> auto_in_d_*
//
// Each FIFO stores every bits_* field of a beat as one packed word per entry.
// The ready signal depends only on the occupancy count, never on a ready input.
// The valid signal and bits come straight from registers.
// A beat written into a FIFO becomes visible on the far side one cycle later.
// A depth of 0 turns that channel into plain wires.
//
// Parameters:
//   A_DEPTH  A-channel entries, 0..8 (0 = wire-through)
//   D_DEPTH  D-channel entries, 0..8 (0 = wire-through)
// Ports:
//   clock, reset         clock, async active-high reset
//   auto_in_a_*          A beats from the crossbar (ready is an output)
//   auto_in_d_*          D beats back to the crossbar (ready is an input)
//   auto_out_a_*         A beats to the fabric (ready is an input)
//   auto_out_d_*         D beats from the fabric (ready is an output)
module tl_ul_buffer #(
  parameter int unsigned A_DEPTH = 2,
  parameter int unsigned D_DEPTH = 2
) (
  input  logic        clock,
  input  logic        reset,
  // A channel, crossbar side
  output logic        auto_in_a_ready,
  input  logic        auto_in_a_valid,
  input  logic [2:0]  auto_in_a_bits_opcode,
  input  logic [2:0]  auto_in_a_bits_param,
  input  logic [3:0]  auto_in_a_bits_size,
  input  logic [4:0]  auto_in_a_bits_source,
  input  logic [27:0] auto_in_a_bits_address,
  input  logic [3:0]  auto_in_a_bits_mask,
  input  logic [31:0] auto_in_a_bits_data,
  input  logic        auto_in_a_bits_corrupt,
  // D channel, crossbar side
  input  logic        auto_in_d_ready,
  output logic        auto_in_d_valid,
  output logic [2:0]  auto_in_d_bits_opcode,
  output logic [1:0]  auto_in_d_bits_param,
  output logic [3:0]  auto_in_d_bits_size,
  output logic [4:0]  auto_in_d_bits_source,
  output logic        auto_in_d_bits_sink,
  output logic        auto_in_d_bits_denied,
  output logic [31:0] auto_in_d_bits_data,
  output logic        auto_in_d_bits_corrupt,
  // A channel, fabric side
  input  logic        auto_out_a_ready,
  output logic        auto_out_a_valid,
  output logic [2:0]  auto_out_a_bits_opcode,
  output logic [2:0]  auto_out_a_bits_param,
  output logic [3:0]  auto_out_a_bits_size,
  output logic [4:0]  auto_out_a_bits_source,
  output logic [27:0] auto_out_a_bits_address,
  output logic [3:0]  auto_out_a_bits_mask,
  output logic [31:0] auto_out_a_bits_data,
  output logic        auto_out_a_bits_corrupt,
  // D channel, fabric side
  output logic        auto_out_d_ready,
  input  logic        auto_out_d_valid,
  input  logic [2:0]  auto_out_d_bits_opcode,
  input  logic [1:0]  auto_out_d_bits_param,
  input  logic [3:0]  auto_out_d_bits_size,
  input  logic [4:0]  auto_out_d_bits_source,
  input  logic        auto_out_d_bits_sink,
  input  logic        auto_out_d_bits_denied,
  input  logic [31:0] auto_out_d_bits_data,
  input  logic        auto_out_d_bits_corrupt
);

  localparam int unsigned AW = 80;  // packed A payload width
  localparam int unsigned DW = 49;  // packed D payload width

  logic [AW-1:0] a_enq_pl, a_deq_pl;
  logic [DW-1:0] d_enq_pl, d_deq_pl;

  // The same field order is used for packing and unpacking.
  // Stored words are therefore never reinterpreted.
  assign a_enq_pl = {auto_in_a_bits_opcode, auto_in_a_bits_param, auto_in_a_bits_size,
                     auto_in_a_bits_source, auto_in_a_bits_address, auto_in_a_bits_mask,
                     auto_in_a_bits_data, auto_in_a_bits_corrupt};
  assign {auto_out_a_bits_opcode, auto_out_a_bits_param, auto_out_a_bits_size,
          auto_out_a_bits_source, auto_out_a_bits_address, auto_out_a_bits_mask,
          auto_out_a_bits_data, auto_out_a_bits_corrupt} = a_deq_pl;

  assign d_enq_pl = {auto_out_d_bits_opcode, auto_out_d_bits_param, auto_out_d_bits_size,
                     auto_out_d_bits_source, auto_out_d_bits_sink, auto_out_d_bits_denied,
                     auto_out_d_bits_data, auto_out_d_bits_corrupt};
  assign {auto_in_d_bits_opcode, auto_in_d_bits_param, auto_in_d_bits_size,
          auto_in_d_bits_source, auto_in_d_bits_sink, auto_in_d_bits_denied,
          auto_in_d_bits_data, auto_in_d_bits_corrupt} = d_deq_pl;

  // ---------------------------------------------------------------------------
  // A channel: auto_in_a -> auto_out_a
  // ---------------------------------------------------------------------------
  if (A_DEPTH == 0) begin : g_a_wire
    assign a_deq_pl         = a_enq_pl;
    assign auto_out_a_valid = auto_in_a_valid;
    assign auto_in_a_ready  = auto_out_a_ready;
  end else begin : g_a_fifo
    localparam int unsigned PtrW = (A_DEPTH > 1) ? $clog2(A_DEPTH) : 1;
    localparam int unsigned CntW = $clog2(A_DEPTH + 1);

    logic [AW-1:0]   mem_q [A_DEPTH];
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            enq, deq;

    assign auto_in_a_ready  = (cnt_q != CntW'(A_DEPTH));
    assign auto_out_a_valid = (cnt_q != '0);
    assign a_deq_pl         = mem_q[rd_ptr_q];

    assign enq = auto_in_a_valid & auto_in_a_ready;
    assign deq = auto_out_a_valid & auto_out_a_ready;

    always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      cnt_d    = cnt_q;
      // Explicit wrap so that depths which are not a power of two work.
      if (enq) begin
        wr_ptr_d = (wr_ptr_q == PtrW'(A_DEPTH - 1)) ? '0 : wr_ptr_q + PtrW'(1);
      end
      if (deq) begin
        rd_ptr_d = (rd_ptr_q == PtrW'(A_DEPTH - 1)) ? '0 : rd_ptr_q + PtrW'(1);
      end
      case ({enq, deq})
        2'b10:   cnt_d = cnt_q + CntW'(1);
        2'b01:   cnt_d = cnt_q - CntW'(1);
        default: cnt_d = cnt_q;
      endcase
    end

    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
        cnt_q    <= '0;
        // Cleared storage keeps the bits outputs at zero out of reset.
        for (int i = 0; i < int'(A_DEPTH); i++) begin
          mem_q[i] <= '0;
        end
      end else begin
        rd_ptr_q <= rd_ptr_d;
        wr_ptr_q <= wr_ptr_d;
        cnt_q    <= cnt_d;
        if (enq) begin
          mem_q[wr_ptr_q] <= a_enq_pl;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // D channel: auto_out_d -> auto_in_d
  // ---------------------------------------------------------------------------
  if (D_DEPTH == 0) begin : g_d_wire
    assign d_deq_pl         = d_enq_pl;
    assign auto_in_d_valid  = auto_out_d_valid;
    assign auto_out_d_ready = auto_in_d_ready;
  end else begin : g_d_fifo
    localparam int unsigned PtrW = (D_DEPTH > 1) ? $clog2(D_DEPTH) : 1;
    localparam int unsigned CntW = $clog2(D_DEPTH + 1);

    logic [DW-1:0]   mem_q [D_DEPTH];
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            enq, deq;

    assign auto_out_d_ready = (cnt_q != CntW'(D_DEPTH));
    assign auto_in_d_valid  = (cnt_q != '0);
    assign d_deq_pl         = mem_q[rd_ptr_q];

    assign enq = auto_out_d_valid & auto_out_d_ready;
    assign deq = auto_in_d_valid & auto_in_d_ready;

    always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      cnt_d    = cnt_q;
      if (enq) begin
        wr_ptr_d = (wr_ptr_q == PtrW'(D_DEPTH - 1)) ? '0 : wr_ptr_q + PtrW'(1);
      end
      if (deq) begin
        rd_ptr_d = (rd_ptr_q == PtrW'(D_DEPTH - 1)) ? '0 : rd_ptr_q + PtrW'(1);
      end
      case ({enq, deq})
        2'b10:   cnt_d = cnt_q + CntW'(1);
        2'b01:   cnt_d = cnt_q - CntW'(1);
        default: cnt_d = cnt_q;
      endcase
    end

    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
        cnt_q    <= '0;
        for (int i = 0; i < int'(D_DEPTH); i++) begin
          mem_q[i] <= '0;
        end
      end else begin
        rd_ptr_q <= rd_ptr_d;
        wr_ptr_q <= wr_ptr_d;
        cnt_q    <= cnt_d;
        if (enq) begin
          mem_q[wr_ptr_q] <= d_enq_pl;
        end
      end
    end
  end

endmodule

// File: tb/tb_tl_ul_buffer.sv
// Testbench for tl_ul_buffer.
// u_dut is the buffered build (A_DEPTH=2, D_DEPTH=3). It is checked every cycle against queue
// models of the two FIFOs.
// u_dut0 is the wire-through build (depth 0). Its outputs must equal its inputs in the same
// cycle.
module tb_tl_ul_buffer;

  localparam int ADep = 2;
  localparam int DDep = 3;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  // Shared stimulus
  logic        in_a_valid, out_a_ready, out_d_valid, in_d_ready;
  logic [79:0] in_a_pl;
  logic [48:0] out_d_pl;

  // Buffered DUT outputs
  logic        in_a_ready, out_a_valid, out_d_ready, in_d_valid;
  logic [2:0]  oa_opcode, oa_param;
  logic [3:0]  oa_size, oa_mask;
  logic [4:0]  oa_source;
  logic [27:0] oa_address;
  logic [31:0] oa_data;
  logic        oa_corrupt;
  logic [2:0]  id_opcode;
  logic [1:0]  id_param;
  logic [3:0]  id_size;
  logic [4:0]  id_source;
  logic        id_sink, id_denied, id_corrupt;
  logic [31:0] id_data;
  logic [79:0] out_a_pl;
  logic [48:0] in_d_pl;
  assign out_a_pl = {oa_opcode, oa_param, oa_size, oa_source, oa_address, oa_mask, oa_data,
                     oa_corrupt};
  assign in_d_pl  = {id_opcode, id_param, id_size, id_source, id_sink, id_denied, id_data,
                     id_corrupt};

  // Wire-through DUT outputs
  logic        z_in_a_ready, z_out_a_valid, z_out_d_ready, z_in_d_valid;
  logic [2:0]  za_opcode, za_param;
  logic [3:0]  za_size, za_mask;
  logic [4:0]  za_source;
  logic [27:0] za_address;
  logic [31:0] za_data;
  logic        za_corrupt;
  logic [2:0]  zd_opcode;
  logic [1:0]  zd_param;
  logic [3:0]  zd_size;
  logic [4:0]  zd_source;
  logic        zd_sink, zd_denied, zd_corrupt;
  logic [31:0] zd_data;
  logic [79:0] z_out_a_pl;
  logic [48:0] z_in_d_pl;
  assign z_out_a_pl = {za_opcode, za_param, za_size, za_source, za_address, za_mask, za_data,
                       za_corrupt};
  assign z_in_d_pl  = {zd_opcode, zd_param, zd_size, zd_source, zd_sink, zd_denied, zd_data,
                       zd_corrupt};

  tl_ul_buffer #(.A_DEPTH(ADep), .D_DEPTH(DDep)) u_dut (
    .clock(clock), .reset(reset),
    .auto_in_a_ready(in_a_ready), .auto_in_a_valid(in_a_valid),
    .auto_in_a_bits_opcode(in_a_pl[79:77]), .auto_in_a_bits_param(in_a_pl[76:74]),
    .auto_in_a_bits_size(in_a_pl[73:70]), .auto_in_a_bits_source(in_a_pl[69:65]),
    .auto_in_a_bits_address(in_a_pl[64:37]), .auto_in_a_bits_mask(in_a_pl[36:33]),
    .auto_in_a_bits_data(in_a_pl[32:1]), .auto_in_a_bits_corrupt(in_a_pl[0]),
    .auto_in_d_ready(in_d_ready), .auto_in_d_valid(in_d_valid),
    .auto_in_d_bits_opcode(id_opcode), .auto_in_d_bits_param(id_param),
    .auto_in_d_bits_size(id_size), .auto_in_d_bits_source(id_source),
    .auto_in_d_bits_sink(id_sink), .auto_in_d_bits_denied(id_denied),
    .auto_in_d_bits_data(id_data), .auto_in_d_bits_corrupt(id_corrupt),
    .auto_out_a_ready(out_a_ready), .auto_out_a_valid(out_a_valid),
    .auto_out_a_bits_opcode(oa_opcode), .auto_out_a_bits_param(oa_param),
    .auto_out_a_bits_size(oa_size), .auto_out_a_bits_source(oa_source),
    .auto_out_a_bits_address(oa_address), .auto_out_a_bits_mask(oa_mask),
    .auto_out_a_bits_data(oa_data), .auto_out_a_bits_corrupt(oa_corrupt),
    .auto_out_d_ready(out_d_ready), .auto_out_d_valid(out_d_valid),
    .auto_out_d_bits_opcode(out_d_pl[48:46]), .auto_out_d_bits_param(out_d_pl[45:44]),
    .auto_out_d_bits_size(out_d_pl[43:40]), .auto_out_d_bits_source(out_d_pl[39:35]),
    .auto_out_d_bits_sink(out_d_pl[34]), .auto_out_d_bits_denied(out_d_pl[33]),
    .auto_out_d_bits_data(out_d_pl[32:1]), .auto_out_d_bits_corrupt(out_d_pl[0])
  );

  tl_ul_buffer #(.A_DEPTH(0), .D_DEPTH(0)) u_dut0 (
    .clock(clock), .reset(reset),
    .auto_in_a_ready(z_in_a_ready), .auto_in_a_valid(in_a_valid),
    .auto_in_a_bits_opcode(in_a_pl[79:77]), .auto_in_a_bits_param(in_a_pl[76:74]),
    .auto_in_a_bits_size(in_a_pl[73:70]), .auto_in_a_bits_source(in_a_pl[69:65]),
    .auto_in_a_bits_address(in_a_pl[64:37]), .auto_in_a_bits_mask(in_a_pl[36:33]),
    .auto_in_a_bits_data(in_a_pl[32:1]), .auto_in_a_bits_corrupt(in_a_pl[0]),
    .auto_in_d_ready(in_d_ready), .auto_in_d_valid(z_in_d_valid),
    .auto_in_d_bits_opcode(zd_opcode), .auto_in_d_bits_param(zd_param),
    .auto_in_d_bits_size(zd_size), .auto_in_d_bits_source(zd_source),
    .auto_in_d_bits_sink(zd_sink), .auto_in_d_bits_denied(zd_denied),
    .auto_in_d_bits_data(zd_data), .auto_in_d_bits_corrupt(zd_corrupt),
    .auto_out_a_ready(out_a_ready), .auto_out_a_valid(z_out_a_valid),
    .auto_out_a_bits_opcode(za_opcode), .auto_out_a_bits_param(za_param),
    .auto_out_a_bits_size(za_size), .auto_out_a_bits_source(za_source),
    .auto_out_a_bits_address(za_address), .auto_out_a_bits_mask(za_mask),
    .auto_out_a_bits_data(za_data), .auto_out_a_bits_corrupt(za_corrupt),
    .auto_out_d_ready(z_out_d_ready), .auto_out_d_valid(out_d_valid),
    .auto_out_d_bits_opcode(out_d_pl[48:46]), .auto_out_d_bits_param(out_d_pl[45:44]),
    .auto_out_d_bits_size(out_d_pl[43:40]), .auto_out_d_bits_source(out_d_pl[39:35]),
    .auto_out_d_bits_sink(out_d_pl[34]), .auto_out_d_bits_denied(out_d_pl[33]),
    .auto_out_d_bits_data(out_d_pl[32:1]), .auto_out_d_bits_corrupt(out_d_pl[0])
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: one queue per channel, bounded by the configured depth.
  logic [79:0] qa[$];
  logic [48:0] qd[$];
  logic [31:0] a_seen[$];  // data field of every A beat taken at the fabric side
  int          d_delivered;

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [79:0] rand_a();
    logic [95:0] r;
    r = {$urandom(), $urandom(), $urandom()};
    return r[79:0];
  endfunction

  function automatic logic [48:0] rand_d();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[48:0];
  endfunction

  // Inputs are driven at posedge+2.
  // This task checks outputs at posedge+3 and then steps both the DUT and the model one clock.
  // It returns at posedge+2.
  task automatic step_cycle();
    bit a_enq, a_deq, d_enq, d_deq;
    logic [79:0] head;
    #1;
    check_eq("a_ready", 128'(in_a_ready), 128'(qa.size() != ADep));
    check_eq("a_valid", 128'(out_a_valid), 128'(qa.size() != 0));
    if (qa.size() != 0) check_eq("a_bits", 128'(out_a_pl), 128'(qa[0]));
    check_eq("d_ready", 128'(out_d_ready), 128'(qd.size() != DDep));
    check_eq("d_valid", 128'(in_d_valid), 128'(qd.size() != 0));
    if (qd.size() != 0) check_eq("d_bits", 128'(in_d_pl), 128'(qd[0]));
    check_eq("z_a_valid", 128'(z_out_a_valid), 128'(in_a_valid));
    check_eq("z_a_ready", 128'(z_in_a_ready), 128'(out_a_ready));
    check_eq("z_a_bits", 128'(z_out_a_pl), 128'(in_a_pl));
    check_eq("z_d_valid", 128'(z_in_d_valid), 128'(out_d_valid));
    check_eq("z_d_ready", 128'(z_out_d_ready), 128'(in_d_ready));
    check_eq("z_d_bits", 128'(z_in_d_pl), 128'(out_d_pl));
    a_enq = in_a_valid && (qa.size() != ADep);
    a_deq = out_a_ready && (qa.size() != 0);
    d_enq = out_d_valid && (qd.size() != DDep);
    d_deq = in_d_ready && (qd.size() != 0);
    @(posedge clock);
    if (a_deq) begin
      head = qa.pop_front();
      a_seen.push_back(head[32:1]);
    end
    if (a_enq) qa.push_back(in_a_pl);
    if (d_deq) begin
      void'(qd.pop_front());
      d_delivered++;
    end
    if (d_enq) qd.push_back(out_d_pl);
    #2;
  endtask

  task automatic idle_inputs();
    in_a_valid  = 1'b0;
    out_d_valid = 1'b0;
  endtask

  initial begin
    logic [79:0] beat;
    reset       = 1'b1;
    in_a_valid  = 1'b0;
    in_a_pl     = '0;
    out_a_ready = 1'b0;
    out_d_valid = 1'b0;
    out_d_pl    = '0;
    in_d_ready  = 1'b0;
    d_delivered = 0;
    repeat (2) @(posedge clock);
    #2;

    // Reset state
    check_eq("rst_a_valid", 128'(out_a_valid), 128'(0));
    check_eq("rst_d_valid", 128'(in_d_valid), 128'(0));
    check_eq("rst_a_ready", 128'(in_a_ready), 128'(1));
    check_eq("rst_d_ready", 128'(out_d_ready), 128'(1));
    check_eq("rst_a_bits", 128'(out_a_pl), 128'(0));
    check_eq("rst_d_bits", 128'(in_d_pl), 128'(0));
    reset = 1'b0;
    step_cycle();

    // A single Get request appears one cycle later with identical fields.
    in_a_valid = 1'b1;
    in_a_pl    = {3'd4, 3'd0, 4'd2, 5'd5, 28'h0001000, 4'hf, 32'h0, 1'b0};
    step_cycle();
    idle_inputs();
    out_a_ready = 1'b1;
    #1;
    check_eq("get_valid", 128'(out_a_valid), 128'(1));
    check_eq("get_opcode", 128'(oa_opcode), 128'(4));
    check_eq("get_addr", 128'(oa_address), 128'(28'h0001000));
    check_eq("get_source", 128'(oa_source), 128'(5));
    step_cycle();
    check_eq("get_drop", 128'(out_a_valid), 128'(0));
    step_cycle();

    // Backpressure: with the fabric stalled, only two of three beats fit.
    out_a_ready = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      in_a_valid = 1'b1;
      in_a_pl    = {3'd0, 3'd0, 4'd2, 5'd3, 28'(32'h100 + 4 * i), 4'hf, 32'(i), 1'b0};
      if (i == 3) begin
        #1;
        check_eq("bp_third_blocked", 128'(in_a_ready), 128'(0));
      end
      if (i < 3) step_cycle();
    end
    a_seen.delete();
    out_a_ready = 1'b1;
    step_cycle();  // beat 1 leaves, beat 3 still blocked
    step_cycle();  // beat 2 leaves, beat 3 enters
    in_a_valid = 1'b0;
    step_cycle();  // beat 3 leaves
    check_eq("bp_count", 128'(a_seen.size()), 128'(3));
    for (int i = 0; i < 3 && i < a_seen.size(); i++) begin
      check_eq("bp_order", 128'(a_seen[i]), 128'(i + 1));
    end

    // Streaming: 16 beats issued back to back.
    a_seen.delete();
    for (int i = 0; i < 16; i++) begin
      beat       = rand_a();
      beat[32:1] = 32'(i);
      in_a_valid = 1'b1;
      in_a_pl    = beat;
      step_cycle();
    end
    in_a_valid = 1'b0;
    step_cycle();
    step_cycle();
    check_eq("stream_count", 128'(a_seen.size()), 128'(16));
    for (int i = 0; i < 16 && i < a_seen.size(); i++) begin
      check_eq("stream_order", 128'(a_seen[i]), 128'(i));
    end

    // Simultaneous enqueue and dequeue while one beat is held.
    out_a_ready = 1'b0;
    in_a_valid  = 1'b1;
    in_a_pl     = rand_a();
    step_cycle();
    beat        = rand_a();
    out_a_ready = 1'b1;
    in_a_pl     = beat;
    step_cycle();
    in_a_valid  = 1'b0;
    out_a_ready = 1'b0;
    #1;
    check_eq("cc_valid", 128'(out_a_valid), 128'(1));
    check_eq("cc_ready", 128'(in_a_ready), 128'(1));
    check_eq("cc_bits", 128'(out_a_pl), 128'(beat));
    step_cycle();
    out_a_ready = 1'b1;
    step_cycle();
    step_cycle();

    // Random traffic on both channels until 1000 D beats have been delivered.
    d_delivered = 0;
    for (int c = 0; c < 20000 && d_delivered < 1000; c++) begin
      out_d_valid = 1'($urandom_range(0, 1));
      out_d_pl    = rand_d();
      in_d_ready  = ($urandom_range(0, 3) != 0);
      in_a_valid  = 1'($urandom_range(0, 1));
      in_a_pl     = rand_a();
      out_a_ready = 1'($urandom_range(0, 1));
      step_cycle();
    end
    check_eq("d_1000_beats", 128'(d_delivered >= 1000), 128'(1));

    // Reset in the middle of traffic, while two A beats and some D beats are buffered.
    idle_inputs();
    out_a_ready = 1'b1;
    in_d_ready  = 1'b1;
    repeat (4) step_cycle();
    out_a_ready = 1'b0;
    in_d_ready  = 1'b0;
    in_a_valid  = 1'b1;
    out_d_valid = 1'b1;
    in_a_pl     = rand_a();
    out_d_pl    = rand_d();
    step_cycle();
    in_a_pl     = rand_a();
    step_cycle();
    idle_inputs();
    #1;
    check_eq("pre_rst_a_valid", 128'(out_a_valid), 128'(1));
    check_eq("pre_rst_a_full", 128'(in_a_ready), 128'(0));
    reset = 1'b1;
    #1;
    check_eq("rst_mid_a_valid", 128'(out_a_valid), 128'(0));
    check_eq("rst_mid_a_ready", 128'(in_a_ready), 128'(1));
    check_eq("rst_mid_d_valid", 128'(in_d_valid), 128'(0));
    check_eq("rst_mid_a_bits", 128'(out_a_pl), 128'(0));
    qa.delete();
    qd.delete();
    repeat (3) @(posedge clock);
    #2;
    reset       = 1'b0;
    out_a_ready = 1'b1;
    in_d_ready  = 1'b1;
    repeat (3) step_cycle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
